// File: rtl/elevator_car_controller.sv
// elevator_car_controller
//   Single-car elevator controller for floors 1..7. Three states (IDLE,
//   MOVING, DOOR_OPEN) share one 16-bit down-counter that times both
//   floor-to-floor travel and the door dwell. Cab calls are latched locally.
//   Hall calls are owned by the dispatcher; this block only reports them as
//   served.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   assignedButton hall calls for this car; floor f: bit 2f-2 down, 2f-1 up
//   carButton      cab buttons, bit f-1 = floor f (a pulse is enough)
//   currentFloor   registered floor number 1..7
//   direction      registered: STOP=00, UP=10, DOWN=01
//   doorOpen       registered, high while the door is open
//   servedButton   one-cycle pulse of hall calls served (assignedButton map)
//   carCallLit     latched cab calls
module elevator_car_controller #(
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] assignedButton,
    input  logic [6:0]  carButton,
    output logic [2:0]  currentFloor,
    output logic [1:0]  direction,
    output logic        doorOpen,
    output logic [13:0] servedButton,
    output logic [6:0]  carCallLit
);
    localparam logic [1:0]  DIR_STOP  = 2'b00;
    localparam logic [1:0]  DIR_UP    = 2'b10;
    localparam logic [1:0]  DIR_DOWN  = 2'b01;
    localparam logic [15:0] MOVE_LOAD = 16'(MOVE_CYCLES - 1);
    localparam logic [15:0] DOOR_LOAD = 16'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

    state_t      state;
    logic [15:0] count;

    function automatic logic [6:0] floor_bit(input logic [2:0] f);
        return 7'h01 << (f - 3'd1);
    endfunction

    // Floors strictly above f (f=7 yields an empty mask).
    function automatic logic [6:0] above_mask(input logic [2:0] f);
        return 7'h7f << f;
    endfunction

    // Floors strictly below f (f=1 yields an empty mask).
    function automatic logic [6:0] below_mask(input logic [2:0] f);
        return floor_bit(f) - 7'h01;
    endfunction

    // Places up/down served flags for floor f into the assignedButton layout.
    function automatic logic [13:0] hall_bits(input logic [2:0] f, input logic up, input logic dn);
        logic [13:0] b;
        logic [3:0]  base;
        b       = '0;
        base    = {f - 3'd1, 1'b0};
        b[base] = dn;
        b[base + 4'd1] = up;
        return b;
    endfunction

    // Hall calls split per floor; down-at-1 and up-at-7 do not exist.
    logic [6:0] hall_up, hall_dn, car_req, any_call;
    logic       unused_end_calls;

    always_comb begin
        hall_up = '0;
        hall_dn = '0;
        for (int i = 0; i < 6; i++) hall_up[i] = assignedButton[2*i+1];
        for (int i = 1; i < 7; i++) hall_dn[i] = assignedButton[2*i];
    end

    assign unused_end_calls = assignedButton[0] ^ assignedButton[13];
    // A cab press counts in the same cycle it arrives, not only once latched.
    assign car_req  = carCallLit | carButton;
    assign any_call = car_req | hall_up | hall_dn;

    // Evaluation at the current floor (IDLE and door expiry).
    logic [6:0] cur_bit;
    logic       here_call, req_above, req_below;
    logic       door_up, door_dn, door_bump;

    assign cur_bit   = floor_bit(currentFloor);
    assign here_call = |(any_call & cur_bit);
    assign req_above = |(any_call & above_mask(currentFloor));
    assign req_below = |(any_call & below_mask(currentFloor));
    // Hall calls at this floor that the open door serves; STOP serves both.
    assign door_up   = |(hall_up & cur_bit) & (direction != DIR_DOWN);
    assign door_dn   = |(hall_dn & cur_bit) & (direction != DIR_UP);
    assign door_bump = |(carButton & cur_bit) | door_up | door_dn;

    // Evaluation at the floor being arrived at. A terminal-floor expiry
    // leaves next_floor unchanged and is evaluated as an arrival there.
    logic [2:0]  next_floor;
    logic [6:0]  arr_bit;
    logic        going_up, arr_car, arr_up, arr_dn, arr_beyond, arr_stop;
    logic [13:0] arr_served;

    assign going_up = (direction == DIR_UP);

    always_comb begin
        next_floor = currentFloor;
        if (going_up && currentFloor != 3'd7)
            next_floor = currentFloor + 3'd1;
        else if (direction == DIR_DOWN && currentFloor != 3'd1)
            next_floor = currentFloor - 3'd1;
    end

    assign arr_bit    = floor_bit(next_floor);
    assign arr_car    = |(car_req & arr_bit);
    assign arr_up     = |(hall_up & arr_bit);
    assign arr_dn     = |(hall_dn & arr_bit);
    assign arr_beyond = going_up ? |(any_call & above_mask(next_floor))
                                 : |(any_call & below_mask(next_floor));
    assign arr_stop   = arr_car | (going_up ? arr_up : arr_dn)
                      | ((going_up ? arr_dn : arr_up) & ~arr_beyond);
    // The opposite-direction call is only served when the car will reverse.
    assign arr_served = hall_bits(next_floor,
                                  going_up ? arr_up : (arr_up & ~arr_beyond),
                                  going_up ? (arr_dn & ~arr_beyond) : arr_dn);

    // Cab lamp for the floor whose door is opening or open is never latched.
    logic [6:0] lit_clr;

    always_comb begin
        lit_clr = '0;
        case (state)
            IDLE:      if (here_call) lit_clr = cur_bit;
            MOVING:    if (count == 16'd0 && arr_stop) lit_clr = arr_bit;
            DOOR_OPEN: lit_clr = cur_bit;
            default:   lit_clr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            currentFloor <= 3'd1;
            direction    <= DIR_STOP;
            doorOpen     <= 1'b0;
            servedButton <= '0;
            carCallLit   <= '0;
        end else begin
            servedButton <= '0;
            carCallLit   <= (carCallLit | carButton) & ~lit_clr;
            case (state)
                IDLE: begin
                    if (here_call) begin
                        state        <= DOOR_OPEN;
                        doorOpen     <= 1'b1;
                        count        <= DOOR_LOAD;
                        servedButton <= hall_bits(currentFloor, door_up, door_dn);
                    end else if (req_above) begin
                        state     <= MOVING;
                        direction <= DIR_UP;
                        count     <= MOVE_LOAD;
                    end else if (req_below) begin
                        state     <= MOVING;
                        direction <= DIR_DOWN;
                        count     <= MOVE_LOAD;
                    end
                end
                MOVING: begin
                    if (count != 16'd0) begin
                        count <= count - 16'd1;
                    end else begin
                        currentFloor <= next_floor;
                        if (arr_stop) begin
                            state        <= DOOR_OPEN;
                            doorOpen     <= 1'b1;
                            count        <= DOOR_LOAD;
                            servedButton <= arr_served;
                        end else if (arr_beyond) begin
                            count <= MOVE_LOAD;
                        end else begin
                            state     <= IDLE;
                            direction <= DIR_STOP;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (door_bump) begin
                        count        <= DOOR_LOAD;
                        servedButton <= hall_bits(currentFloor, door_up, door_dn);
                    end else if (count != 16'd0) begin
                        count <= count - 16'd1;
                    end else begin
                        doorOpen <= 1'b0;
                        count    <= MOVE_LOAD;
                        // Keep going the same way if possible; STOP prefers up.
                        if (direction == DIR_DOWN ? req_below : req_above) begin
                            state     <= MOVING;
                            direction <= (direction == DIR_DOWN) ? DIR_DOWN : DIR_UP;
                        end else if (direction == DIR_DOWN ? req_above : req_below) begin
                            state     <= MOVING;
                            direction <= (direction == DIR_DOWN) ? DIR_UP : DIR_DOWN;
                        end else begin
                            state     <= IDLE;
                            direction <= DIR_STOP;
                            count     <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_car_controller.sv
// Scoreboard bench for elevator_car_controller (MOVE_CYCLES=4, DOOR_CYCLES=3).
// Stimulus pushes hand-computed expected events (floor change, direction
// change, door open, door close) with their cycle stamps; a negedge monitor
// pops and compares whenever the DUT shows such an event.
module tb_elevator_car_controller;
    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] UP   = 2'b10;
    localparam logic [1:0] DN   = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] assignedButton;
    logic [6:0]  carButton;
    logic [2:0]  currentFloor;
    logic [1:0]  direction;
    logic        doorOpen;
    logic [13:0] servedButton;
    logic [6:0]  carCallLit;

    elevator_car_controller #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .assignedButton(assignedButton),
        .carButton(carButton), .currentFloor(currentFloor),
        .direction(direction), .doorOpen(doorOpen),
        .servedButton(servedButton), .carCallLit(carCallLit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  floor;
        logic [1:0]  dir;
        logic [13:0] served;
        logic [6:0]  lit;
        int          len;
    } ev_t;

    ev_t floor_q[$], dir_q[$], open_q[$], close_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL unexpected_%s: got %0h expected no event (cycle %0d)", name, act, cyc);
    endtask

    task automatic ex_floor(input int c, input logic [2:0] f, input logic [6:0] l);
        floor_q.push_back('{cyc: c, floor: f, dir: STOP, served: 14'h0, lit: l, len: 0});
    endtask
    task automatic ex_dir(input int c, input logic [1:0] d);
        dir_q.push_back('{cyc: c, floor: 3'd0, dir: d, served: 14'h0, lit: 7'h0, len: 0});
    endtask
    task automatic ex_open(input int c, input logic [2:0] f, input logic [1:0] d,
                           input logic [13:0] s, input logic [6:0] l);
        open_q.push_back('{cyc: c, floor: f, dir: d, served: s, lit: l, len: 0});
    endtask
    task automatic ex_close(input int c, input int n, input logic [1:0] d, input logic [6:0] l);
        close_q.push_back('{cyc: c, floor: 3'd0, dir: d, served: 14'h0, lit: l, len: n});
    endtask

    // Monitor
    logic [2:0] p_floor;
    logic [1:0] p_dir;
    logic       p_door;
    int         door_len = 0;

    always @(negedge clk) begin
        ev_t e;
        if (doorOpen === 1'b1) door_len = (p_door === 1'b1) ? door_len + 1 : 1;
        if (mon_en) begin
            if (currentFloor !== p_floor) begin
                if (floor_q.size() == 0) unexpected("floor", currentFloor);
                else begin
                    e = floor_q.pop_front();
                    chk("floor_cycle", cyc, e.cyc);
                    chk("floor", currentFloor, e.floor);
                    chk("floor_lit", carCallLit, e.lit);
                end
            end
            if (direction !== p_dir) begin
                if (dir_q.size() == 0) unexpected("direction", direction);
                else begin
                    e = dir_q.pop_front();
                    chk("dir_cycle", cyc, e.cyc);
                    chk("direction", direction, e.dir);
                end
            end
            if (doorOpen === 1'b1 && p_door !== 1'b1) begin
                if (open_q.size() == 0) unexpected("door_open", currentFloor);
                else begin
                    e = open_q.pop_front();
                    chk("open_cycle", cyc, e.cyc);
                    chk("open_floor", currentFloor, e.floor);
                    chk("open_dir", direction, e.dir);
                    chk("open_served", servedButton, e.served);
                    chk("open_lit", carCallLit, e.lit);
                end
            end
            if (doorOpen === 1'b0 && p_door === 1'b1) begin
                if (close_q.size() == 0) unexpected("door_close", currentFloor);
                else begin
                    e = close_q.pop_front();
                    chk("close_cycle", cyc, e.cyc);
                    chk("door_len", door_len, e.len);
                    chk("close_dir", direction, e.dir);
                    chk("close_lit", carCallLit, e.lit);
                end
            end
        end
        p_floor = currentFloor;
        p_dir   = direction;
        p_door  = doorOpen;
    end

    // Advance n negedges; the dispatcher drops hall calls once served.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            assignedButton = assignedButton & ~servedButton;
        end
    endtask

    initial begin
        int t;
        reset = 1'b1;
        assignedButton = '0;
        carButton = '0;
        run(3);
        reset = 1'b0;
        chk("rst_floor", currentFloor, 3'd1);
        chk("rst_dir", direction, STOP);
        chk("rst_door", doorOpen, 1'b0);
        chk("rst_served", servedButton, 14'h0);
        chk("rst_lit", carCallLit, 7'h0);
        mon_en = 1'b1;
        run(2);

        // Cab call to floor 3 from floor 1
        t = cyc;
        carButton = 7'b0000100;
        ex_dir(t+1, UP);
        ex_floor(t+5, 3'd2, 7'b0000100);
        ex_floor(t+9, 3'd3, 7'h0);
        ex_open(t+9, 3'd3, UP, 14'h0, 7'h0);
        ex_close(t+12, 3, STOP, 7'h0);
        ex_dir(t+12, STOP);
        run(1); carButton = '0; run(15);

        // Floor 3 -> 4, cab button for floor 4 pressed on the 2nd door cycle
        t = cyc;
        carButton = 7'b0001000;
        ex_dir(t+1, UP);
        ex_floor(t+5, 3'd4, 7'h0);
        ex_open(t+5, 3'd4, UP, 14'h0, 7'h0);
        ex_close(t+10, 5, STOP, 7'h0);
        ex_dir(t+10, STOP);
        run(1); carButton = '0; run(5);
        carButton = 7'b0001000;
        run(1); carButton = '0; run(10);

        // Reset while moving between floors 4 and 3
        t = cyc;
        carButton = 7'b0000001;
        ex_dir(t+1, DN);
        ex_floor(t+3, 3'd1, 7'h0);
        ex_dir(t+3, STOP);
        run(1); carButton = '0; run(1);
        reset = 1'b1;
        run(1); reset = 1'b0; run(8);

        // Floor 5 up and floor 3 down from floor 1: pass 3, stop 5, reverse, stop 3
        t = cyc;
        assignedButton = 14'h0210;
        ex_dir(t+1, UP);
        ex_floor(t+5, 3'd2, 7'h0);
        ex_floor(t+9, 3'd3, 7'h0);
        ex_floor(t+13, 3'd4, 7'h0);
        ex_floor(t+17, 3'd5, 7'h0);
        ex_open(t+17, 3'd5, UP, 14'h0200, 7'h0);
        ex_close(t+20, 3, DN, 7'h0);
        ex_dir(t+20, DN);
        ex_floor(t+24, 3'd4, 7'h0);
        ex_floor(t+28, 3'd3, 7'h0);
        ex_open(t+28, 3'd3, DN, 14'h0010, 7'h0);
        ex_close(t+31, 3, STOP, 7'h0);
        ex_dir(t+31, STOP);
        run(36);

        // Back down to floor 1
        t = cyc;
        carButton = 7'b0000001;
        ex_dir(t+1, DN);
        ex_floor(t+5, 3'd2, 7'b0000001);
        ex_floor(t+9, 3'd1, 7'h0);
        ex_open(t+9, 3'd1, DN, 14'h0, 7'h0);
        ex_close(t+12, 3, STOP, 7'h0);
        ex_dir(t+12, STOP);
        run(1); carButton = '0; run(15);

        // Floor 7 down call only: travel to the top, serve, then stop
        t = cyc;
        assignedButton = 14'h1000;
        ex_dir(t+1, UP);
        for (int f = 2; f <= 7; f++) ex_floor(t + 4*(f-1) + 1, 3'(f), 7'h0);
        ex_open(t+25, 3'd7, UP, 14'h1000, 7'h0);
        ex_close(t+28, 3, STOP, 7'h0);
        ex_dir(t+28, STOP);
        run(32);

        // Nonexistent calls (down at 1, up at 7) must be ignored while idle at 7
        assignedButton = 14'h2001;
        run(8);
        assignedButton = '0;
        run(2);

        // Floor 7 -> 2
        t = cyc;
        carButton = 7'b0000010;
        ex_dir(t+1, DN);
        for (int f = 6; f >= 3; f--) ex_floor(t + 4*(7-f) + 1, 3'(f), 7'b0000010);
        ex_floor(t+21, 3'd2, 7'h0);
        ex_open(t+21, 3'd2, DN, 14'h0, 7'h0);
        ex_close(t+24, 3, STOP, 7'h0);
        ex_dir(t+24, STOP);
        run(1); carButton = '0; run(27);

        // Cab and up-hall call together at the idle floor: one door cycle
        t = cyc;
        carButton = 7'b0000010;
        assignedButton = 14'h0008;
        ex_open(t+1, 3'd2, STOP, 14'h0008, 7'h0);
        ex_close(t+4, 3, STOP, 7'h0);
        run(1); carButton = '0; run(9);

        while (floor_q.size() > 0) begin
            ev_t e; e = floor_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_floor: got none expected floor %0d at cycle %0d", e.floor, e.cyc);
        end
        while (dir_q.size() > 0) begin
            ev_t e; e = dir_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_dir: got none expected dir %0b at cycle %0d", e.dir, e.cyc);
        end
        while (open_q.size() > 0) begin
            ev_t e; e = open_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_open: got none expected open at floor %0d cycle %0d", e.floor, e.cyc);
        end
        while (close_q.size() > 0) begin
            ev_t e; e = close_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_close: got none expected close at cycle %0d", e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
